// File: rtl/piezo_sched.sv
// piezo_sched: shares one piezo tone player between three tune sources
// (0 = obstacle alarm, 1 = battery-low, 2 = charge fanfare). Requests are
// latched, granted by fixed priority (lowest index wins), launched with a
// one-cycle go, and tracked through the player's busy. Source 0 may preempt
// a lower-priority tune; a silent gap separates normal tunes; a watchdog
// aborts a hung player. All outputs are registered.
module piezo_sched #(
    parameter logic        FAST_SIM = 1'b0,
    parameter logic [24:0] GAP_CYC  = 25'd5_000_000,
    parameter logic [26:0] MAX_PLAY = 27'd100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    input  logic       busy,
    output logic       go,
    output logic       abort,
    output logic [1:0] tune_sel,
    output logic [2:0] grant,
    output logic [2:0] ack,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_PLAY,
        ST_DRAIN,
        ST_GAP
    } state_t;

    // One shared counter serves LAUNCH, PLAY and GAP; it is wide enough to
    // hold MAX_PLAY plus one step, so the >= compares can never see a wrap.
    localparam int                CNT_W       = 28;
    localparam logic [CNT_W-1:0] CNT_ONE     = 28'd1;
    localparam logic [CNT_W-1:0] STEP        = FAST_SIM ? 28'd16 : 28'd1;
    localparam logic [CNT_W-1:0] GAP_LIM     = {3'd0, GAP_CYC};
    localparam logic [CNT_W-1:0] PLAY_LIM    = {1'b0, MAX_PLAY};
    localparam logic [CNT_W-1:0] LAUNCH_LAST = 28'd15;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_pending;
    logic               r_preempt;
    logic               r_go;
    logic               r_abort;
    logic [1:0]         r_tune_sel;
    logic [2:0]         r_grant;
    logic [2:0]         r_ack;
    logic               r_err;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_step;
    logic [2:0]         w_clr;
    logic               w_preempt_nxt;
    logic               w_go_nxt;
    logic               w_abort_nxt;
    logic [1:0]         w_tune_sel_nxt;
    logic [2:0]         w_grant_nxt;
    logic [2:0]         w_ack_nxt;
    logic               w_err_nxt;
    logic               w_launch;
    logic               w_can_launch;
    logic [2:0]         w_pick_oh;
    logic [1:0]         w_pick_idx;

    // Lowest set pending bit wins; isolate it as a one-hot and an index.
    assign w_pick_oh    = r_pending & (~r_pending + 3'd1);
    assign w_pick_idx   = w_pick_oh[2] ? 2'd2 : (w_pick_oh[1] ? 2'd1 : 2'd0);
    assign w_can_launch = en && (r_pending != 3'b000);
    assign w_cnt_step   = r_cnt + STEP;

    // Next-state, counter and next-output decode for the scheduler FSM.
    always_comb begin
        // NOTE: every signal gets its default first, so no path through the
        // case leaves one unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_clr          = 3'b000;
        w_preempt_nxt  = r_preempt;
        w_go_nxt       = 1'b0;
        w_abort_nxt    = 1'b0;
        w_ack_nxt      = 3'b000;
        w_tune_sel_nxt = r_tune_sel;
        w_grant_nxt    = r_grant;
        w_err_nxt      = r_err;
        w_launch       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = 3'b000;
                w_launch    = w_can_launch;
            end
            ST_LAUNCH: begin
                if (busy) begin
                    w_state_nxt = ST_PLAY;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= LAUNCH_LAST) begin
                    // Player never started: flag it and drop this request.
                    w_err_nxt   = 1'b1;
                    w_clr       = r_grant;
                    w_grant_nxt = 3'b000;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_PLAY: begin
                if (!busy) begin
                    w_ack_nxt   = r_grant;
                    w_clr       = r_grant;
                    w_grant_nxt = 3'b000;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else if (w_cnt_step >= PLAY_LIM) begin
                    // Hung player: stop it and drop this request.
                    w_abort_nxt   = 1'b1;
                    w_err_nxt     = 1'b1;
                    w_clr         = r_grant;
                    w_preempt_nxt = 1'b0;
                    w_state_nxt   = ST_DRAIN;
                end else if (r_pending[0] && (r_grant != 3'b001)) begin
                    // Alarm preempts; the victim keeps its pending bit and
                    // replays from the start later.
                    w_abort_nxt   = 1'b1;
                    w_preempt_nxt = 1'b1;
                    w_state_nxt   = ST_DRAIN;
                end else begin
                    w_cnt_nxt = w_cnt_step;
                end
            end
            ST_DRAIN: begin
                if (!busy) begin
                    w_preempt_nxt = 1'b0;
                    w_grant_nxt   = 3'b000;
                    w_cnt_nxt     = '0;
                    if (!r_preempt) begin
                        w_state_nxt = ST_GAP;
                    end else if (w_can_launch) begin
                        // After a preempt the alarm launches with no gap.
                        w_launch = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                w_grant_nxt = 3'b000;
                if (w_cnt_step >= GAP_LIM) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_step;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 3'b000;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_launch) begin
            w_go_nxt       = 1'b1;
            w_grant_nxt    = w_pick_oh;
            w_tune_sel_nxt = w_pick_idx;
            w_cnt_nxt      = '0;
            w_state_nxt    = ST_LAUNCH;
        end
    end

    // State, counter, pending bits and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pending  <= 3'b000;
            r_preempt  <= 1'b0;
            r_go       <= 1'b0;
            r_abort    <= 1'b0;
            r_tune_sel <= 2'd0;
            r_grant    <= 3'b000;
            r_ack      <= 3'b000;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            // A new request in the same cycle as the clear wins.
            r_pending  <= (r_pending & ~w_clr) | req;
            r_preempt  <= w_preempt_nxt;
            r_go       <= w_go_nxt;
            r_abort    <= w_abort_nxt;
            r_tune_sel <= w_tune_sel_nxt;
            r_grant    <= w_grant_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign go       = r_go;
    assign abort    = r_abort;
    assign tune_sel = r_tune_sel;
    assign grant    = r_grant;
    assign ack      = r_ack;
    assign err      = r_err;

endmodule
